mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `single_memory` instance between the instruction-fetch unit and the load/store unit. It accepts word fetches and byte/half/word loads and stores on independent request ports and issues at most one access per cycle to the memory. It returns read data one cycle later on the port that issued the read. It sits between the CPU front-end/LSU and `single_memory`, and owns all memory control pins.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
// Pure declarations: no logic, no latency, no flow control.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 10;
  localparam int MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_D  = 1'b1
  } win_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data requesters; combinational, zero latency.
// Loser simply sees no grant and holds its request. MEM_ARB_FAIR_EN alternates on contention.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_FAIR_EN
  input  win_t last_win,
`endif
  output logic pick_if,
  output logic pick_d
);

  always_comb begin
    pick_d = d_req;
`ifdef MEM_ARB_FAIR_EN
    // On contention the port that lost last time gets its turn.
    if (if_req && d_req) begin
      pick_d = (last_win == WIN_IF);
    end
`endif
    pick_if = if_req && !pick_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between fetch and load/store ports; grant same cycle, read data 1 cycle later.
// Requesters hold until gnt; one access per cycle. Optional MEM_ARB_FAIR_EN alternates on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic              d_b,
  input  logic              d_h,
  input  logic              d_u,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_wen,
  output logic              m_b,
  output logic              m_h,
  output logic              m_u,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout
);

  own_t own;
  own_t own_nxt;
  logic pick_if;
  logic pick_d;

`ifdef MEM_ARB_FAIR_EN
  win_t last_win;

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_win (last_win),
    .pick_if  (pick_if),
    .pick_d   (pick_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win <= WIN_IF;
    end else if (if_req && d_req) begin
      last_win <= pick_d ? WIN_D : WIN_IF;
    end
  end
`else
  mem_arb_pick u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .pick_if (pick_if),
    .pick_d  (pick_d)
  );
`endif

  // Grants are masked during reset so every output sits at 0.
  assign if_gnt = rst & pick_if;
  assign d_gnt  = rst & pick_d;

  always_comb begin
    own_nxt = OWN_NONE;
    if (pick_d) begin
      if (!d_wen) own_nxt = OWN_D;
    end else if (pick_if) begin
      own_nxt = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own <= OWN_NONE;
    end else begin
      own <= own_nxt;
    end
  end

  always_comb begin
    m_wen  = 1'b0;
    m_b    = 1'b0;
    m_h    = 1'b0;
    m_u    = 1'b0;
    m_addr = '0;
    m_din  = '0;
    if (d_gnt) begin
      m_wen  = d_wen;
      m_b    = d_b;
      m_h    = d_h;
      m_u    = d_u;
      m_addr = d_addr;
      m_din  = d_wdata;
    end else if (if_gnt) begin
      m_addr = if_addr;
    end
  end

  assign if_rvalid = (own == OWN_IF);
  assign d_rvalid  = (own == OWN_D);
  assign if_rdata  = if_rvalid ? m_dout : '0;
  assign d_rdata   = d_rvalid  ? m_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed read-first memory stand-in and a read scoreboard.
// Honours MEM_ARB_FAIR_EN for expected grant order.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_wen, d_b, d_h, d_u;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_wen, m_b, m_h, m_u;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_b(d_b), .d_h(d_h), .d_u(d_u),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_wen(m_wen), .m_b(m_b), .m_h(m_h), .m_u(m_u),
    .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] init_byte(int a);
    logic [31:0] w;
    logic [31:0] s;
    case (a >> 2)
      0:       w = 32'hCAFEF00D;
      1:       w = 32'h12345678;
      2:       w = 32'h0BADBEEF;
      default: w = (a * 32'h01010101) ^ 32'h5A3C96E1;
    endcase
    s = w >> (8 * (a % 4));
    return s[7:0];
  endfunction

  // Memory stand-in: registered read data, read-before-write.
  logic [7:0] mem [0:1023];
  initial begin
    logic [31:0] rd;
    int a;
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
    m_dout = '0;
    forever begin
      @(posedge clk);
      a = int'(m_addr);
      if (m_b)      rd = {{24{~m_u & mem[a][7]}}, mem[a]};
      else if (m_h) rd = {{16{~m_u & mem[(a+1)%1024][7]}}, mem[(a+1)%1024], mem[a]};
      else          rd = {mem[(a+3)%1024], mem[(a+2)%1024], mem[(a+1)%1024], mem[a]};
      if (m_wen) begin
        mem[a] = m_din[7:0];
        if (!m_b) mem[(a+1)%1024] = m_din[15:8];
        if (!m_b && !m_h) begin
          mem[(a+2)%1024] = m_din[23:16];
          mem[(a+3)%1024] = m_din[31:24];
        end
      end
      m_dout <= rd;
    end
  end

  // Reference memory and expected-read scoreboard.
  logic [7:0] ref_mem [0:1023];

  typedef struct {
    int          due;
    logic        is_if;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] ref_ld(int a, logic b, logic h, logic u);
    logic [31:0] v;
    if (b)      v = {{24{~u & ref_mem[a][7]}}, ref_mem[a]};
    else if (h) v = {{16{~u & ref_mem[(a+1)%1024][7]}}, ref_mem[(a+1)%1024], ref_mem[a]};
    else        v = {ref_mem[(a+3)%1024], ref_mem[(a+2)%1024], ref_mem[(a+1)%1024], ref_mem[a]};
    return v;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          cyc = 0;
  logic        lw = 1'b0;
  logic [3:0]  dg_hist = '0;
  logic [31:0] s_if_rdata, s_d_rdata;

  // One cycle: sample mid-cycle, check grants/pins/returns, update models, advance.
  task automatic tick();
    logic        e_if, e_d, r_if, r_d;
    logic [31:0] r_dat, e_din;
    logic [13:0] e_ctl;
    exp_t        e;
    @(negedge clk);
    e_if = 1'b0; e_d = 1'b0; r_if = 1'b0; r_d = 1'b0; r_dat = '0;
    if (!rst) begin
      sb.delete();
      lw = 1'b0;
      chk("rst_outs",
          {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_wen, m_b, m_h, m_u, m_addr, m_din}, '0);
    end else begin
      e_d  = d_req && (!if_req || !FAIR || !lw);
      e_if = if_req && !e_d;
      if (if_req && d_req) lw = e_d;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        r_if  = e.is_if;
        r_d   = !e.is_if;
        r_dat = e.data;
      end
    end
    e_ctl = e_d ? {d_wen, d_b, d_h, d_u, d_addr} : (e_if ? {4'b0, if_addr} : 14'd0);
    e_din = e_d ? d_wdata : 32'd0;
    chk("if_gnt", if_gnt, e_if);
    chk("d_gnt", d_gnt, e_d);
    chk("m_ctl", {m_wen, m_b, m_h, m_u, m_addr}, e_ctl);
    if (!e_if) chk("m_din", m_din, e_din);
    chk("if_rvalid", if_rvalid, r_if);
    chk("if_rdata", if_rdata, r_if ? r_dat : 32'd0);
    chk("d_rvalid", d_rvalid, r_d);
    chk("d_rdata", d_rdata, r_d ? r_dat : 32'd0);
    s_if_rdata = if_rdata;
    s_d_rdata  = d_rdata;
    dg_hist    = {dg_hist[2:0], d_gnt};
    if (e_if) begin
      e.due = cyc + 1; e.is_if = 1'b1; e.data = ref_ld(int'(if_addr), 1'b0, 1'b0, 1'b0);
      sb.push_back(e);
    end
    if (e_d && !d_wen) begin
      e.due = cyc + 1; e.is_if = 1'b0; e.data = ref_ld(int'(d_addr), d_b, d_h, d_u);
      sb.push_back(e);
    end
    if (e_d && d_wen) begin
      ref_mem[int'(d_addr)] = d_wdata[7:0];
      if (!d_b) ref_mem[(int'(d_addr)+1)%1024] = d_wdata[15:8];
      if (!d_b && !d_h) begin
        ref_mem[(int'(d_addr)+2)%1024] = d_wdata[23:16];
        ref_mem[(int'(d_addr)+3)%1024] = d_wdata[31:24];
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    d_b = 1'b0; d_h = 1'b0; d_u = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic fetch(logic [AW-1:0] a);
    d_req = 1'b0; if_req = 1'b1; if_addr = a;
    tick();
  endtask

  task automatic d_op(logic wen, logic b, logic h, logic u, logic [AW-1:0] a, logic [DW-1:0] wd);
    if_req = 1'b0; d_req = 1'b1;
    d_wen = wen; d_b = b; d_h = h; d_u = u; d_addr = a; d_wdata = wd;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    idle();
    rst = 1'b0;
    // Requests during reset must be ignored.
    if_req = 1'b1; d_req = 1'b1; d_addr = 10'h020; if_addr = 10'h004;
    tick();
    tick();
    idle();
    rst = 1'b1;
    tick();

    // Isolated fetch.
    fetch(10'h004);
    idle();
    tick();
    chk("fetch_data", s_if_rdata, 32'h12345678);

    // Contention for 4 cycles.
    if_req = 1'b1; if_addr = 10'h008;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 10'h020;
    for (int i = 0; i < 4; i++) tick();
`ifdef MEM_ARB_FAIR_EN
    chk("cont_order", dg_hist, 4'b1010);
`else
    chk("cont_order", dg_hist, 4'b1111);
`endif
    idle();
    tick();

    // Store byte then signed byte load.
    d_op(1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 32'h123456A5);
    d_op(1'b0, 1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
    idle();
    tick();
    chk("sb_byte", s_d_rdata, 32'hFFFFFFA5);

    // Half store, unsigned and signed half loads, word load.
    d_op(1'b1, 1'b0, 1'b1, 1'b0, 10'h022, 32'hDEAD8001);
    d_op(1'b0, 1'b0, 1'b1, 1'b1, 10'h022, 32'h0);
    d_op(1'b0, 1'b0, 1'b1, 1'b0, 10'h022, 32'h0);
    d_op(1'b0, 1'b0, 1'b0, 1'b0, 10'h020, 32'h0);
    chk("lh_signed", s_d_rdata, 32'hFFFF8001);

    // Store granted while an earlier load returns.
    d_op(1'b0, 1'b0, 1'b0, 1'b0, 10'h030, 32'h0);
    d_op(1'b1, 1'b0, 1'b0, 1'b0, 10'h030, 32'hA1B2C3D4);
    d_op(1'b0, 1'b0, 1'b0, 1'b0, 10'h030, 32'h0);
    idle();
    tick();
    chk("st_visible", s_d_rdata, 32'hA1B2C3D4);

    // Back-to-back fetches, then interleaved fetch/load.
    fetch(10'h000);
    fetch(10'h004);
    fetch(10'h008);
    d_op(1'b0, 1'b0, 1'b0, 1'b0, 10'h010, 32'h0);
    fetch(10'h030);
    d_op(1'b0, 1'b1, 1'b0, 1'b1, 10'h031, 32'h0);
    idle();
    tick();

    // Reset in the cycle after a load grant.
    d_op(1'b0, 1'b0, 1'b0, 1'b0, 10'h004, 32'h0);
    rst = 1'b0;
    tick();
    idle();
    rst = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
